// File: rtl/arith_pkg.sv
// Shared arithmetic-cell definitions: controller state encoding and default operand width.
package arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - b_in, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    assign d     = x ^ y ^ b_in;
    assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (a - b), LSB first, behind a start/busy/done handshake.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             d_bit,
    output logic             d_valid
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_nxt;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_borrow_out;
    logic             r_d_bit;
    logic             r_d_valid;

    logic [WIDTH-1:0] w_sa_nxt;
    logic [WIDTH-1:0] w_sb_nxt;
    logic [WIDTH-1:0] w_diff_nxt;
    logic             w_borrow_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_borrow_out_nxt;
    logic             w_d_bit_nxt;
    logic             w_d_valid_nxt;

    logic             w_d;
    logic             w_bo;
    logic             w_last;

    full_subtractor u_fs (
        .x     (r_sa[0]),
        .y     (r_sb[0]),
        .b_in  (r_borrow),
        .d     (w_d),
        .b_out (w_bo)
    );

    assign w_last = (r_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for the datapath and registered outputs; done is a single-cycle pulse.
    always_comb begin
        w_sa_nxt         = r_sa;
        w_sb_nxt         = r_sb;
        w_diff_nxt       = r_diff;
        w_borrow_nxt     = r_borrow;
        w_cnt_nxt        = r_cnt;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_borrow_out_nxt = r_borrow_out;
        w_d_bit_nxt      = r_d_bit;
        w_d_valid_nxt    = r_d_valid;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_sa_nxt     = a;
                    w_sb_nxt     = b;
                    w_borrow_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                    w_busy_nxt   = 1'b1;
                end
            end
            S_RUN: begin
                w_diff_nxt    = {w_d, r_diff[WIDTH-1:1]};
                w_sa_nxt      = r_sa >> 1;
                w_sb_nxt      = r_sb >> 1;
                w_borrow_nxt  = w_bo;
                w_cnt_nxt     = r_cnt + CNT_W'(1);
                w_d_bit_nxt   = w_d;
                w_d_valid_nxt = 1'b1;
                if (w_last) begin
                    w_busy_nxt       = 1'b0;
                    w_done_nxt       = 1'b1;
                    w_borrow_out_nxt = w_bo;
                end
            end
            S_DONE: begin
                w_d_valid_nxt = 1'b0;
            end
            default: begin
                w_busy_nxt    = 1'b0;
                w_d_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sa         <= '0;
            r_sb         <= '0;
            r_diff       <= '0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_borrow_out <= 1'b0;
            r_d_bit      <= 1'b0;
            r_d_valid    <= 1'b0;
        end else begin
            r_sa         <= w_sa_nxt;
            r_sb         <= w_sb_nxt;
            r_diff       <= w_diff_nxt;
            r_borrow     <= w_borrow_nxt;
            r_cnt        <= w_cnt_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_borrow_out <= w_borrow_out_nxt;
            r_d_bit      <= w_d_bit_nxt;
            r_d_valid    <= w_d_valid_nxt;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign d_bit      = r_d_bit;
    assign d_valid    = r_d_valid;

endmodule
